// File: rtl/dot_accum_pkg.sv
// Shared definitions for the dot_accum block.
//   state_e : block FSM states (idle, accumulating, result held)
//   OpW     : operand width of x and y
//   ProdW   : width of one x*y product
//   CntW    : width of the term counter
package dot_accum_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned OpW   = 4;
  localparam int unsigned ProdW = 8;
  localparam int unsigned CntW  = 4;

endpackage

// File: rtl/dot_accum_if.sv
// Operand/result handshake bundle for dot_accum.
//   in_valid/in_ready/x/y/in_last : operand pair stream into the block
//   out_valid/out_ready           : result handshake
//   acc_out/term_count            : saturated sum and number of accepted terms
//   sat_flag/forced_last          : saturation seen; block closed by the term limit
// master drives operands and out_ready; slave is the accumulator.
interface dot_accum_if
  import dot_accum_pkg::*;
#(
  parameter int unsigned ACC_W = 10
) ();

  logic             in_valid;
  logic             in_ready;
  logic [OpW-1:0]   x;
  logic [OpW-1:0]   y;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CntW-1:0]  term_count;
  logic             sat_flag;
  logic             forced_last;

  modport master (
    output in_valid, x, y, in_last, out_ready,
    input  in_ready, out_valid, acc_out, term_count, sat_flag, forced_last
  );

  modport slave (
    input  in_valid, x, y, in_last, out_ready,
    output in_ready, out_valid, acc_out, term_count, sat_flag, forced_last
  );

endinterface

// File: rtl/dot_accum_mult_impl.sv
// Unsigned 4x4 multiplier producing a full-width 8-bit product.
//   a, b    : unsigned operands
//   product : a*b, 0..225
module mult_impl
  import dot_accum_pkg::*;
(
  input  logic [OpW-1:0]   a,
  input  logic [OpW-1:0]   b,
  output logic [ProdW-1:0] product
);

  assign product = ProdW'(a) * ProdW'(b);

endmodule

// File: rtl/dot_accum.sv
// Saturating dot-product accumulator. Accepts a block of (x, y) pairs, sums x*y with
// clipping at 2^ACC_W-1, and presents the result until the consumer takes it. A block
// closes on in_last or when MAX_TERMS terms have been accepted.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of dot_accum_if (operand stream in, result out)
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int unsigned ACC_W     = 10,
  parameter int unsigned MAX_TERMS = 8
) (
  input logic        clk,
  input logic        rst,
  dot_accum_if.slave bus
);

  localparam logic [ACC_W-1:0] AccMax   = {ACC_W{1'b1}};
  localparam logic [CntW-1:0]  MaxTerms = CntW'(MAX_TERMS);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             forced_q, forced_d;

  logic [ProdW-1:0] product;
  logic [ACC_W:0]   sum;
  logic             in_xfer;
  logic             out_xfer;

  mult_impl u_mult (
    .a       (bus.x),
    .b       (bus.y),
    .product (product)
  );

  // One spare bit so an overflow is visible before clipping.
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(product);

  assign bus.in_ready    = (state_q != StDone);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.acc_out     = acc_q;
  assign bus.term_count  = cnt_q;
  assign bus.sat_flag    = sat_q;
  assign bus.forced_last = forced_q;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    forced_d = forced_q;

    unique case (state_q)
      StIdle, StAccum: begin
        if (in_xfer) begin
          if (state_q == StIdle) begin
            // First term of a block starts a fresh accumulation.
            acc_d    = ACC_W'(product);
            cnt_d    = 4'd1;
            sat_d    = 1'b0;
            forced_d = 1'b0;
          end else begin
            if (sum > {1'b0, AccMax}) begin
              acc_d = AccMax;
              sat_d = 1'b1;
            end else begin
              acc_d = sum[ACC_W-1:0];
            end
            cnt_d = cnt_q + 4'd1;
          end

          if (bus.in_last) begin
            state_d = StDone;
          end else if (cnt_d == MaxTerms) begin
            state_d  = StDone;
            forced_d = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StDone: begin
        if (out_xfer) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      forced_q <= forced_d;
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Self-checking bench for dot_accum: directed blocks plus randomized blocks checked
// against a sum-of-products reference computed per block.
module tb_dot_accum;

  localparam int unsigned AccW     = 10;
  localparam int unsigned MaxTerms = 8;
  localparam int unsigned AccMax   = (1 << AccW) - 1;

  logic clk;
  logic rst;

  dot_accum_if #(.ACC_W(AccW)) bus ();

  dot_accum #(
    .ACC_W     (AccW),
    .MAX_TERMS (MaxTerms)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned xq[$];
  int unsigned yq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned clip(input int unsigned s);
    return (s > AccMax) ? AccMax : s;
  endfunction

  // Feeds xq/yq as one block. use_last marks the final pair; without it the block
  // must be exactly MaxTerms long. bub bubbles precede every term after the first;
  // hold is the number of cycles the result is stalled with noisy inputs.
  task automatic run_block(input bit use_last, input int bub, input int hold);
    int unsigned sum;
    int          n;
    int unsigned exp_acc;
    bit          exp_sat;
    bit          exp_forced;
    n   = xq.size();
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat (bub) begin
          bus.in_valid = 1'b0;
          bus.x        = 4'($urandom);
          bus.y        = 4'($urandom);
          bus.in_last  = 1'($urandom);
          step();
          check("bubble_cnt", 32'(bus.term_count), 32'(i));
          check("bubble_acc", 32'(bus.acc_out), clip(sum));
        end
      end
      bus.in_valid = 1'b1;
      bus.x        = 4'(xq[i]);
      bus.y        = 4'(yq[i]);
      bus.in_last  = use_last && (i == n - 1);
      check("in_ready_open", 32'(bus.in_ready), 32'd1);
      step();
      sum += xq[i] * yq[i];
      if (i < n - 1) begin
        check("partial_acc", 32'(bus.acc_out), clip(sum));
        check("open_out_valid", 32'(bus.out_valid), 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    exp_acc    = clip(sum);
    exp_sat    = sum > AccMax;
    exp_forced = !use_last && (n == MaxTerms);
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("in_ready_done", 32'(bus.in_ready), 32'd0);
    check("acc_out", 32'(bus.acc_out), exp_acc);
    check("term_count", 32'(bus.term_count), 32'(n));
    check("sat_flag", 32'(bus.sat_flag), 32'(exp_sat));
    check("forced_last", 32'(bus.forced_last), 32'(exp_forced));

    bus.out_ready = 1'b0;
    repeat (hold) begin
      bus.in_valid = 1'($urandom);
      bus.x        = 4'($urandom);
      bus.y        = 4'($urandom);
      bus.in_last  = 1'($urandom);
      step();
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_acc", 32'(bus.acc_out), exp_acc);
      check("hold_cnt", 32'(bus.term_count), 32'(n));
      check("hold_flags", {30'd0, bus.sat_flag, bus.forced_last},
            {30'd0, exp_sat, exp_forced});
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic load(input int unsigned xv, input int unsigned yv, input int n);
    xq.delete();
    yq.delete();
    for (int i = 0; i < n; i++) begin
      xq.push_back(xv);
      yq.push_back(yv);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_acc", 32'(bus.acc_out), 32'd0);
    check("rst_cnt", 32'(bus.term_count), 32'd0);
    check("rst_flags", {30'd0, bus.sat_flag, bus.forced_last}, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // (3,4),(5,6),(15,15) -> 267, with a stalled result.
    xq = '{3, 5, 15};
    yq = '{4, 6, 15};
    run_block(1'b1, 0, 5);

    // Five max products saturate a 10-bit accumulator.
    load(15, 15, 5);
    run_block(1'b1, 0, 0);

    // Eight (1,1) without in_last: closed by the term limit, ninth pair stalls.
    load(1, 1, MaxTerms);
    run_block(1'b0, 0, 3);

    // Bubbles between terms.
    xq = '{2, 4};
    yq = '{3, 4};
    run_block(1'b1, 3, 0);

    // Single-term block.
    load(7, 7, 1);
    run_block(1'b1, 0, 1);

    // Reset mid-block, with a transfer offered on the reset edge.
    bus.in_valid = 1'b1;
    bus.x        = 4'd2;
    bus.y        = 4'd5;
    bus.in_last  = 1'b0;
    step();
    bus.x = 4'd3;
    step();
    check("mid_cnt", 32'(bus.term_count), 32'd2);
    rst         = 1'b1;
    bus.in_last = 1'b1;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("mid_rst_acc", 32'(bus.acc_out), 32'd0);
    check("mid_rst_cnt", 32'(bus.term_count), 32'd0);
    check("mid_rst_flags", {30'd0, bus.sat_flag, bus.forced_last}, 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) begin
      step();
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    end
    load(2, 2, 1);
    run_block(1'b1, 0, 0);

    // Randomized blocks.
    for (int b = 0; b < 40; b++) begin
      int  n;
      bit  use_last;
      n = $urandom_range(1, MaxTerms);
      use_last = (n < MaxTerms) ? 1'b1 : 1'($urandom);
      xq.delete();
      yq.delete();
      for (int i = 0; i < n; i++) begin
        xq.push_back($urandom_range(0, 15));
        yq.push_back($urandom_range(0, 15));
      end
      run_block(use_last, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
